divisor_8bits: RTL and testbench

// - Sequential unsigned divider, restoring algorithm: q = a / b, r = a % b.
// - Inverse of the ULA's add path. It reuses an N-bit ripple subtractor that

---
 rtl/ula_pkg.sv | 7 +
 rtl/subtrator_8bits.sv | 36 +++
 rtl/divisor_8bits.sv | 105 ++++++++++
 tb/tb_divisor_8bits.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: constants shared across the ULA datapath blocks.
package ula_pkg;
    localparam int ULA_N = 8;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_CALC = 1'b1;
    typedef enum logic {S_IDLE = ST_IDLE, S_CALC = ST_CALC} state_t;
endpackage

// File: rtl/subtrator_8bits.sv
// subtrator_8bits: ripple subtractor a - b built as a + ~b + 1 from full adders.
// The chain is N+1 bits wide; cout=1 means no borrow (a >= b).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module subtrator_8bits
    import ula_pkg::*;
#(
    parameter int N = ULA_N
) (
    input  logic [N:0] a,
    input  logic [N:0] b,
    output logic [N:0] diff,
    output logic       cout
);
    logic [N+1:0] c;
    assign c[0] = 1'b1;
    for (genvar i = 0; i <= N; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (c[i]),
            .s   (diff[i]),
            .cout(c[i+1])
        );
    end
    assign cout = c[N+1];
endmodule

// File: rtl/divisor_8bits.sv
// divisor_8bits: sequential restoring unsigned divider, one quotient bit per clock.
// Divide-by-zero completes in IDLE with q=all ones, r=a, dz=1.
module divisor_8bits
    import ula_pkg::*;
#(
    parameter int N  = ULA_N,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   d_q, d_d, b_q, b_d, q_q, q_d, r_q, r_d;
    logic [N:0]     p_q, p_d;
    logic           dz_q, dz_d, done_q, done_d;
    logic [N:0]     t, diff, p_nx;
    logic [N-1:0]   d_nx;
    logic           no_borrow;
    // P never exceeds B after a restoring step, so its MSB stays clear
    logic           unused_p_msb;
    assign unused_p_msb = p_q[N];
    assign t = {p_q[N-1:0], d_q[N-1]};
    subtrator_8bits #(.N(N)) u_sub (
        .a   (t),
        .b   ({1'b0, b_q}),
        .diff(diff),
        .cout(no_borrow)
    );
    assign p_nx = no_borrow ? diff : t;
    assign d_nx = {d_q[N-2:0], no_borrow};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        b_d     = b_q;
        p_d     = p_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && b == '0) begin
                q_d    = '1;
                r_d    = a;
                dz_d   = 1'b1;
                done_d = 1'b1;
            end else if (start) begin
                d_d     = a;
                b_d     = b;
                p_d     = '0;
                cnt_d   = '0;
                state_d = S_CALC;
            end
        end else begin
            p_d   = p_nx;
            d_d   = d_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                q_d     = d_nx;
                r_d     = p_nx[N-1:0];
                dz_d    = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            b_q     <= b_d;
            p_q     <= p_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end
    assign busy = (state_q == S_CALC);
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
endmodule

// File: tb/tb_divisor_8bits.sv
// tb_divisor_8bits: directed and random checks of the sequential divider.
module tb_divisor_8bits;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, dz;
    logic [7:0] q, r;
    int n_vec = 0;
    int n_err = 0;

    divisor_8bits dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input bit sync,
                          output int lat, output int nbusy);
        if (sync) @(negedge clk);
        a = aa; b = bb; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        lat = 0; nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(posedge clk); @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %0b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %0b want 0", done); end
        n_vec++; if ({q, r} !== 16'h0) begin n_err++; $display("FAIL reset q/r got %0d/%0d want 0/0", q, r); end
        n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL reset dz got %0b want 0", dz); end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int lat, nb;
        run_op(8'd100, 8'd7, 1'b1, lat, nb);
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL normal latency got %0d want 8", lat); end
        n_vec++; if (nb !== 8) begin n_err++; $display("FAIL normal busy cycles got %0d want 8", nb); end
        n_vec++; if (q !== 8'd14) begin n_err++; $display("FAIL normal q got %0d want 14", q); end
        n_vec++; if (r !== 8'd2) begin n_err++; $display("FAIL normal r got %0d want 2", r); end
        n_vec++; if (dz !== 1'b0) begin n_err++; $display("FAIL normal dz got %0b want 0", dz); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL normal done pulse got %0b want 0", done); end
        n_vec++; if (q !== 8'd14 || r !== 8'd2) begin n_err++; $display("FAIL normal hold got %0d/%0d want 14/2", q, r); end
    endtask

    task automatic test_boundary();
        logic [7:0] va [3] = '{8'd255, 8'd5, 8'd0};
        logic [7:0] vb [3] = '{8'd1, 8'd9, 8'd3};
        logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd0};
        logic [7:0] er [3] = '{8'd0, 8'd5, 8'd0};
        int lat, nb;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b1, lat, nb);
            n_vec++; if (q !== eq[i] || r !== er[i] || lat !== 8) begin
                n_err++; $display("FAIL boundary %0d/%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=8",
                                  va[i], vb[i], q, r, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_op(8'd37, 8'd0, 1'b1, lat, nb);
        n_vec++; if (lat !== 0) begin n_err++; $display("FAIL divzero latency got %0d want 0 edges after start", lat); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL divzero busy got %0b want 0", busy); end
        n_vec++; if (q !== 8'hFF || r !== 8'd37) begin n_err++; $display("FAIL divzero q/r got %0h/%0d want ff/37", q, r); end
        n_vec++; if (dz !== 1'b1) begin n_err++; $display("FAIL divzero dz got %0b want 1", dz); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL divzero after got done=%0b busy=%0b want 0/0", done, busy); end
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid busy/done got %0b/%0b want 0/0", busy, done); end
        n_vec++; if (q !== 8'd0 || r !== 8'd0 || dz !== 1'b0) begin n_err++; $display("FAIL rstmid q/r/dz got %0d/%0d/%0b want 0/0/0", q, r, dz); end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd100, 8'd7, 1'b1, lat, nb);
        n_vec++; if (q !== 8'd14 || r !== 8'd2 || lat !== 8) begin n_err++; $display("FAIL rstmid rerun got q=%0d r=%0d lat=%0d want 14/2/8", q, r, lat); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        a = 8'd200; b = 8'd13; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd0;
        lat = 4;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL busyign latency got %0d want 8", lat); end
        n_vec++; if (q !== 8'd15 || r !== 8'd5) begin n_err++; $display("FAIL busyign q/r got %0d/%0d want 15/5", q, r); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL busyign after got busy=%0b done=%0b want 0/0", busy, done); end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        run_op(8'd200, 8'd13, 1'b1, lat, nb);
        n_vec++; if (q !== 8'd15 || r !== 8'd5) begin n_err++; $display("FAIL b2b first got %0d/%0d want 15/5", q, r); end
        run_op(8'd9, 8'd3, 1'b0, lat, nb);
        n_vec++; if (lat !== 8 || nb !== 8) begin n_err++; $display("FAIL b2b timing got lat=%0d busy=%0d want 8/8", lat, nb); end
        n_vec++; if (q !== 8'd3 || r !== 8'd0) begin n_err++; $display("FAIL b2b second got %0d/%0d want 3/0", q, r); end
    endtask

    task automatic test_random();
        logic [7:0] aa, bb;
        int lat, nb;
        for (int i = 0; i < 1000; i++) begin
            aa = 8'($urandom_range(0, 255));
            bb = 8'($urandom_range(1, 255));
            run_op(aa, bb, 1'b1, lat, nb);
            n_vec++; if (q !== aa / bb || r !== aa % bb || dz !== 1'b0 || lat !== 8) begin
                n_err++; $display("FAIL random %0d/%0d got q=%0d r=%0d dz=%0b lat=%0d want q=%0d r=%0d dz=0 lat=8",
                                  aa, bb, q, r, dz, lat, aa / bb, aa % bb);
            end
            @(negedge clk);
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL random done pulse %0d/%0d got %0b want 0", aa, bb, done); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_boundary();
        test_div_zero();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
